// File: rtl/uart_tx_ctrl_pkg.sv
// Shared constants for the UART transmit controller: register map,
// status/control bit positions and the sequencer state encoding.
package uart_ctrl_pkg;

  localparam logic [1:0] REG_DATA  = 2'd0;
  localparam logic [1:0] REG_CTRL  = 2'd1;
  localparam logic [1:0] REG_DIVLO = 2'd2;
  localparam logic [1:0] REG_DIVHI = 2'd3;

  localparam int ST_ACTIVE = 7;
  localparam int ST_FULL   = 6;
  localparam int ST_EMPTY  = 5;
  localparam int ST_OVF    = 4;
  localparam int ST_ERR    = 3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_CLR   = 2;

  // Cycles the sequencer waits for UartTx to raise busy before flagging err.
  localparam int WAIT_BUSY_CYCLES = 2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Bus pins and UartTx/baud-generator side of the transmit controller.
// master = CPU/system side, slave = the controller itself.
interface uart_tx_ctrl_if;
  logic        cs_n;
  logic        rw;
  logic [1:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_oe;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_latch;
  logic [15:0] baud_div;

  modport master (
    output cs_n, rw, addr, wdata, tx_busy,
    input  rdata, rdata_oe, tx_data, tx_latch, baud_div
  );

  modport slave (
    input  cs_n, rw, addr, wdata, tx_busy,
    output rdata, rdata_oe, tx_data, tx_latch, baud_div
  );
endinterface

// File: rtl/uart_tx_ctrl_fifo.sv
// Byte FIFO for the transmit controller. Pushes to a full FIFO and pops
// from an empty one are ignored; flush overrides both.
module tx_fifo
  import uart_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic [7:0]          i_wdata,
  input  logic                i_pop,
  input  logic                i_flush,
  output logic                o_full,
  output logic                o_empty,
  output logic [7:0]          o_head,
  output logic [DEPTH_LOG2:0] o_count
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  // Full/empty are judged on the pre-update count, so a push into a full
  // FIFO is dropped even when a pop happens in the same cycle.
  assign w_do_push = i_push & ~o_full  & ~i_flush;
  assign w_do_pop  = i_pop  & ~o_empty & ~i_flush;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_ONE;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Bus-facing UART transmit controller: cs_n synchronizer, register file,
// transmit FIFO and the sequencer that hands bytes to UartTx.
module uart_tx_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 2,
  parameter logic [15:0] DIV_DEFAULT = 16'd1667
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_ctrl_if.slave bus
);

  logic                r_cs_s1, r_cs_s2, r_cs_s3;
  logic                w_strobe;
  logic                w_wr, w_wr_data, w_wr_ctrl, w_wr_divlo, w_wr_divhi;
  logic                w_flush, w_clr;
  logic                w_full, w_empty, w_pop;
  logic [7:0]          w_head;
  logic [DEPTH_LOG2:0] w_count;
  logic [2:0]          w_count3;
  logic [7:0]          w_status;
  logic [7:0]          w_rdata_nxt;

  logic                r_en, r_ovf, r_err;
  logic [7:0]          r_div_lo;
  logic [15:0]         r_baud_div;
  logic [7:0]          r_rdata;
  logic [7:0]          r_tx_data;
  logic                r_tx_latch;
  logic [0:0]          r_wait_cnt;
  tx_state_e           r_state;

  // cs_n is asynchronous: two flops for metastability, a third for the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_s1 <= 1'b1;
      r_cs_s2 <= 1'b1;
      r_cs_s3 <= 1'b1;
    end else begin
      r_cs_s1 <= bus.cs_n;
      r_cs_s2 <= r_cs_s1;
      r_cs_s3 <= r_cs_s2;
    end
  end

  assign w_strobe   = r_cs_s3 & ~r_cs_s2;
  assign w_wr       = w_strobe & ~bus.rw;
  assign w_wr_data  = w_wr & (bus.addr == REG_DATA);
  assign w_wr_ctrl  = w_wr & (bus.addr == REG_CTRL);
  assign w_wr_divlo = w_wr & (bus.addr == REG_DIVLO);
  assign w_wr_divhi = w_wr & (bus.addr == REG_DIVHI);
  assign w_flush    = w_wr_ctrl & bus.wdata[CTRL_FLUSH];
  assign w_clr      = w_wr_ctrl & bus.wdata[CTRL_CLR];
  assign w_pop      = (r_state == S_ISSUE);
  assign w_count3   = 3'(w_count);

  tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_wr_data),
    .i_wdata (bus.wdata),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_comb begin
    w_status           = {5'b0, w_count3};
    w_status[ST_ACTIVE] = (r_state != S_IDLE);
    w_status[ST_FULL]   = w_full;
    w_status[ST_EMPTY]  = w_empty;
    w_status[ST_OVF]    = r_ovf;
    w_status[ST_ERR]    = r_err;
    w_rdata_nxt        = w_status;
    case (bus.addr)
      REG_CTRL:  w_rdata_nxt = {7'b0, r_en};
      REG_DIVLO: w_rdata_nxt = r_baud_div[7:0];
      REG_DIVHI: w_rdata_nxt = r_baud_div[15:8];
      default:   w_rdata_nxt = w_status;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en       <= 1'b0;
      r_ovf      <= 1'b0;
      r_div_lo   <= '0;
      r_baud_div <= DIV_DEFAULT;
      r_rdata    <= '0;
    end else begin
      r_rdata <= w_rdata_nxt;
      if (w_wr_ctrl)  r_en <= bus.wdata[CTRL_EN];
      if (w_clr)                     r_ovf <= 1'b0;
      else if (w_wr_data && w_full)  r_ovf <= 1'b1;
      if (w_wr_divlo) r_div_lo <= bus.wdata;
      // Both halves change together so the baud generator never sees a torn value.
      if (w_wr_divhi) r_baud_div <= {bus.wdata, r_div_lo};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tx_latch <= 1'b0;
      r_tx_data  <= '0;
      r_err      <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_tx_latch <= 1'b0;
      if (w_clr) r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_en && !w_empty && !bus.tx_busy) begin
            r_tx_data  <= w_head;
            r_tx_latch <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_wait_cnt == 1'(WAIT_BUSY_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rdata    = r_rdata;
  assign bus.rdata_oe = ~r_cs_s2 & bus.rw;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_latch = r_tx_latch;
  assign bus.baud_div = r_baud_div;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: a queue-based model of the FIFO and
// registers predicts latched bytes and read data; a monitor compares them.
module tb_uart_tx_ctrl;
  import uart_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int FRAME = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_ctrl_if bus();

  uart_tx_ctrl #(.DEPTH_LOG2(2), .DIV_DEFAULT(16'd1667)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int fall_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UartTx stand-in: busy for FRAME cycles starting the cycle after a latch.
  logic model_busy_en = 1'b1;
  int   busy_cnt = 0;
  always @(posedge clk) begin
    if (bus.tx_latch && model_busy_en) busy_cnt <= FRAME;
    else if (busy_cnt != 0)            busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0);

  typedef struct {
    logic [7:0] data;
    int         lat;
  } tx_exp_t;

  tx_exp_t    tx_q[$];
  logic [7:0] rd_q[$];
  string      rd_name_q[$];

  logic [7:0]  m_fifo[$];
  logic        m_en = 1'b0, m_ovf = 1'b0, m_err = 1'b0;
  logic [7:0]  m_lo = 8'h00;
  logic [15:0] m_div = 16'd1667;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] m_status();
    logic [7:0] s;
    s = {5'b0, 3'(m_fifo.size())};
    s[ST_FULL]  = (m_fifo.size() == DEPTH);
    s[ST_EMPTY] = (m_fifo.size() == 0);
    s[ST_OVF]   = m_ovf;
    s[ST_ERR]   = m_err;
    return s;
  endfunction

  // Moves up to n queued bytes (all when n < 0) into the expected-latch queue.
  function automatic void m_drain(input int n, input int first_lat);
    int k = 0;
    tx_exp_t e;
    while (m_fifo.size() > 0 && (n < 0 || k < n)) begin
      e.data = m_fifo.pop_front();
      e.lat  = (k == 0) ? first_lat : -1;
      tx_q.push_back(e);
      if (!model_busy_en) m_err = 1'b1;
      k++;
    end
  endfunction

  task automatic bus_access(input logic rw_i, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.rw    = rw_i;
    bus.addr  = a;
    bus.wdata = d;
    #($urandom_range(1, 4));
    fall_cyc = cyc;
    bus.cs_n = 1'b0;
    repeat (5) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wr_data(input logic [7:0] b, input int lat);
    if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
    else                       m_ovf = 1'b1;
    if (m_en) m_drain(-1, lat);
    bus_access(1'b0, REG_DATA, b);
  endtask

  task automatic wr_ctrl(input logic [7:0] v, input int n_drain);
    m_en = v[CTRL_EN];
    if (v[CTRL_FLUSH]) m_fifo.delete();
    if (v[CTRL_CLR]) begin
      m_ovf = 1'b0;
      m_err = 1'b0;
    end
    if (m_en) m_drain(n_drain, -1);
    bus_access(1'b0, REG_CTRL, v);
  endtask

  task automatic rd(input logic [1:0] a, input string name);
    logic [7:0] e;
    case (a)
      REG_CTRL:  e = {7'b0, m_en};
      REG_DIVLO: e = m_div[7:0];
      REG_DIVHI: e = m_div[15:8];
      default:   e = m_status();
    endcase
    rd_q.push_back(e);
    rd_name_q.push_back(name);
    bus_access(1'b1, a, 8'h00);
  endtask

  task automatic wr_div(input logic [7:0] lo, input logic [7:0] hi);
    m_lo = lo;
    bus_access(1'b0, REG_DIVLO, lo);
    check("baud_div_after_lo", bus.baud_div, m_div);
    m_div = {hi, m_lo};
    bus_access(1'b0, REG_DIVHI, hi);
    check("baud_div_after_hi", bus.baud_div, m_div);
  endtask

  // Monitor: compares every latch pulse and every read against the queues.
  initial begin
    logic    prev_latch = 1'b0;
    logic    prev_oe = 1'b0;
    tx_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.tx_latch) begin
          check("latch_while_busy", bus.tx_busy, 1'b0);
          check("latch_width", prev_latch, 1'b0);
          if (tx_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_latch: tx_data 0x%0h, expected no latch (t=%0t)", bus.tx_data, $time);
          end else begin
            e = tx_q.pop_front();
            check("tx_data", bus.tx_data, e.data);
            if (e.lat >= 0) check("latch_latency", cyc - fall_cyc, e.lat);
          end
        end
        if (bus.rdata_oe && !prev_oe) begin
          if (rd_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_read: rdata 0x%0h, expected no read", bus.rdata);
          end else begin
            check(rd_name_q.pop_front(), bus.rdata, rd_q.pop_front());
          end
        end
      end
      prev_latch = bus.tx_latch;
      prev_oe    = bus.rdata_oe;
    end
  end

  initial begin
    int n;
    bus.cs_n  = 1'b1;
    bus.rw    = 1'b1;
    bus.addr  = 2'd0;
    bus.wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx_latch", bus.tx_latch, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_rdata", bus.rdata, 8'h00);
    check("rst_rdata_oe", bus.rdata_oe, 1'b0);
    check("rst_baud_div", bus.baud_div, 16'd1667);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rd(REG_DATA, "rst_status");
    rd(REG_CTRL, "rst_ctrl");
    rd(REG_DIVLO, "rst_divlo");
    rd(REG_DIVHI, "rst_divhi");

    // Single byte with the sequencer idle.
    wr_ctrl(8'h01, -1);
    wr_data(8'h55, 4);
    repeat (40) @(negedge clk);
    rd(REG_DATA, "single_status");
    rd(REG_CTRL, "single_ctrl");

    // Fill past full with en off, then release.
    wr_ctrl(8'h00, -1);
    for (int i = 0; i < 5; i++) wr_data(8'h10 + 8'(i), -1);
    rd(REG_DATA, "full_status");
    wr_ctrl(8'h01, -1);
    repeat (150) @(negedge clk);
    rd(REG_DATA, "drained_status");
    wr_ctrl(8'h05, -1);
    rd(REG_DATA, "ovf_cleared_status");

    wr_div(8'h34, 8'h12);
    rd(REG_DIVLO, "div_lo");
    rd(REG_DIVHI, "div_hi");

    // UartTx never answers: err must latch.
    model_busy_en = 1'b0;
    wr_data(8'hA5, 4);
    repeat (20) @(negedge clk);
    rd(REG_DATA, "err_status");
    wr_ctrl(8'h04, -1);
    rd(REG_DATA, "err_cleared_status");
    rd(REG_CTRL, "err_cleared_ctrl");
    model_busy_en = 1'b1;

    // Three bytes queued, flush while the first is on the wire.
    for (int i = 0; i < 3; i++) wr_data(8'h61 + 8'(i), -1);
    rd(REG_DATA, "three_queued_status");
    wr_ctrl(8'h01, 1);
    wr_ctrl(8'h03, 0);
    repeat (60) @(negedge clk);
    rd(REG_DATA, "flushed_status");

    // Randomized traffic.
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 2))
        0, 1: begin
          wr_data(8'($urandom), 4);
          repeat (30) @(negedge clk);
        end
        default: wr_div(8'($urandom), 8'($urandom));
      endcase
    end
    rd(REG_DATA, "rand_status");

    for (int it = 0; it < 3; it++) begin
      wr_ctrl(8'h04, -1);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) wr_data(8'($urandom), -1);
      rd(REG_DATA, "burst_status");
      wr_ctrl(8'h01, -1);
      repeat (150) @(negedge clk);
      rd(REG_DATA, "burst_done_status");
      rd(REG_DIVLO, "burst_divlo");
    end

    repeat (50) @(negedge clk);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
